// File: rtl/team_06_echo_history_buffer.sv
// Circular sample history for the echo effect: stores written-back samples
// and returns the sample written 'offset' writes before the newest one.
module team_06_echo_history_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8192,
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] save_audio,
  input  logic              save_strobe,
  input  logic              clear,
  input  logic              search,
  input  logic [ADDR_W-1:0] offset,
  output logic [DATA_W-1:0] past_output,
  output logic              past_valid,
  output logic              busy,
  output logic [ADDR_W:0]   fill_count
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    RESP
  } state_t;

  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   fill_q, fill_d;
  logic              hit_q, hit_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic [DATA_W-1:0] ram_q;
  logic [ADDR_W-1:0] rd_addr;
  logic              lookup;
  logic              wr_en;

  logic [DATA_W-1:0] mem [DEPTH];

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    hit_d    = hit_q;
    out_d    = out_q;
    lookup   = 1'b0;
    wr_en    = save_strobe & ~clear;
    rd_addr  = wr_ptr_q - ADDR_W'(1) - offset;
    if (save_strobe) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (fill_q != FULL) begin
        fill_d = fill_q + (ADDR_W+1)'(1);
      end
    end
    unique case (state_q)
      IDLE: begin
        if (search) begin
          lookup  = 1'b1;
          hit_d   = {1'b0, offset} < fill_q;
          state_d = FETCH;
        end
      end
      FETCH: begin
        out_d   = hit_q ? ram_q : '0;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Flush wins over everything; the displayed sample is kept.
    if (clear) begin
      state_d  = IDLE;
      wr_ptr_d = '0;
      fill_d   = '0;
      out_d    = out_q;
      lookup   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      fill_q   <= '0;
      hit_q    <= 1'b0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
      hit_q    <= hit_d;
      out_q    <= out_d;
    end
  end

  // Read-before-write: a same-edge write to rd_addr returns the old sample.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= save_audio;
    end
    if (lookup) begin
      ram_q <= mem[rd_addr];
    end
  end

  assign past_output = out_q;
  assign past_valid  = (state_q == RESP);
  assign busy        = (state_q != IDLE);
  assign fill_count  = fill_q;

endmodule

// File: tb/tb_team_06_echo_history_buffer.sv
// Scoreboard bench for the echo history buffer, run with a 16-deep history.
module tb_team_06_echo_history_buffer;

  localparam int DW = 8;
  localparam int DP = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] save_audio = '0;
  logic          save_strobe = 1'b0;
  logic          clear = 1'b0;
  logic          search = 1'b0;
  logic [AW-1:0] offset = '0;
  logic [DW-1:0] past_output;
  logic          past_valid;
  logic          busy;
  logic [AW:0]   fill_count;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [DW-1:0] exp_q[$];
  int            cyc_q[$];

  team_06_echo_history_buffer #(
    .DATA_W(DW),
    .DEPTH (DP),
    .ADDR_W(AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .save_audio (save_audio),
    .save_strobe(save_strobe),
    .clear      (clear),
    .search     (search),
    .offset     (offset),
    .past_output(past_output),
    .past_valid (past_valid),
    .busy       (busy),
    .fill_count (fill_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (past_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_valid got=%h want=none t=%0t",
                 past_output, $time);
      end else begin
        logic [DW-1:0] e;
        int c;
        e = exp_q.pop_front();
        c = cyc_q.pop_front();
        if (past_output !== e || cyc != c) begin
          bad++;
          $display("FAIL lookup got=%h@%0d want=%h@%0d",
                   past_output, cyc, e, c);
        end
      end
    end
  end

  task automatic chk(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  task automatic wr(input logic [DW-1:0] v);
    @(negedge clk);
    save_strobe = 1'b1;
    save_audio  = v;
    @(negedge clk);
    save_strobe = 1'b0;
  endtask

  task automatic look(input logic [AW-1:0] off, input logic [DW-1:0] e);
    @(negedge clk);
    search = 1'b1;
    offset = off;
    exp_q.push_back(e);
    cyc_q.push_back(cyc + 2);
    @(negedge clk);
    search = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    // 1: reset holds everything at zero despite activity
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      search      = i[0];
      save_strobe = ~i[0];
      save_audio  = 8'hE0 + 8'(i);
    end
    chk("rst_out", int'(past_output), 0);
    chk("rst_valid", int'(past_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_fill", int'(fill_count), 0);
    @(negedge clk);
    search = 1'b0;
    save_strobe = 1'b0;
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // 2: basic lookups and fill gating
    wr(8'h11);
    wr(8'h22);
    wr(8'h33);
    chk("fill3", int'(fill_count), 3);
    look(4'd0, 8'h33);
    look(4'd2, 8'h11);
    look(4'd3, 8'h00);

    // 3: wrap with saturation
    pulse_clear();
    for (int i = 0; i < 20; i++) wr(8'(i));
    chk("fill_sat", int'(fill_count), 16);
    look(4'd0, 8'd19);
    look(4'd15, 8'd4);

    // 4: same-cycle search+write, then a dropped search while busy
    wr(8'h55);
    @(negedge clk);
    search = 1'b1;
    offset = 4'd0;
    save_strobe = 1'b1;
    save_audio = 8'hAA;
    exp_q.push_back(8'h55);
    cyc_q.push_back(cyc + 2);
    @(negedge clk);
    save_strobe = 1'b0;
    chk("busy_fetch", int'(busy), 1);
    offset = 4'd1;
    @(negedge clk);
    search = 1'b0;
    repeat (3) @(negedge clk);
    look(4'd0, 8'hAA);

    // full buffer, write lands on rd_addr during FETCH: old sample wins
    @(negedge clk);
    search = 1'b1;
    offset = 4'd15;
    exp_q.push_back(8'd6);
    cyc_q.push_back(cyc + 2);
    @(negedge clk);
    search = 1'b0;
    save_strobe = 1'b1;
    save_audio = 8'h77;
    @(negedge clk);
    save_strobe = 1'b0;
    repeat (2) @(negedge clk);
    look(4'd0, 8'h77);

    // 5: clear during FETCH aborts the lookup
    @(negedge clk);
    search = 1'b1;
    offset = 4'd1;
    @(negedge clk);
    search = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    repeat (3) @(negedge clk);
    chk("clr_fill", int'(fill_count), 0);
    chk("clr_hold", int'(past_output), 'h77);
    look(4'd0, 8'h00);

    // 6: async reset while in FETCH
    wr(8'h42);
    @(negedge clk);
    search = 1'b1;
    offset = 4'd0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_valid", int'(past_valid), 0);
    chk("arst_out", int'(past_output), 0);
    chk("arst_fill", int'(fill_count), 0);
    search = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_busy", int'(busy), 0);
    chk("post_fill", int'(fill_count), 0);
    look(4'd0, 8'h00);

    repeat (4) @(negedge clk);
    chk("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
